// File: rtl/rv32i_types.sv
// Shared types and defaults for the rv32i core control slice.
// The pipeline controller and its testbench both import this package.
package rv32i_types;

    localparam int NUM_STAGES_DEF    = 5;
    localparam int NUM_MEM_PORTS_DEF = 2;
    localparam int HAZ_STAGE_DEF     = 1;
    localparam int FLUSH_DEPTH_DEF   = 2;
    localparam int CNT_W_DEF         = 32;

    localparam int IMEM_PORT = 0;
    localparam int DMEM_PORT = 1;

    // What the pipeline does with its stage registers in the current cycle.
    typedef enum logic [1:0] {
        SHIFT_HOLD,
        SHIFT_NORMAL,
        SHIFT_HAZARD,
        SHIFT_FLUSH
    } shift_mode_e;

endpackage

// File: rtl/perf_counter.sv
// Saturating up-counter used for the pipeline performance statistics.
// Sticks at all-ones instead of wrapping.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline advance/stall controller: gates stage loads on memory responses,
// inserts load-use bubbles, kills young stages on flush, and counts events.
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int NUM_STAGES    = NUM_STAGES_DEF,
    parameter int NUM_MEM_PORTS = NUM_MEM_PORTS_DEF,
    parameter int HAZ_STAGE     = HAZ_STAGE_DEF,
    parameter int FLUSH_DEPTH   = FLUSH_DEPTH_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_MEM_PORTS-1:0] mem_req,
    input  logic [NUM_MEM_PORTS-1:0] mem_resp,
    input  logic                     fetch_valid,
    input  logic                     hazard,
    input  logic                     flush,
    output logic [NUM_STAGES-1:0]    stage_load,
    output logic [NUM_STAGES-1:0]    stage_valid,
    output logic                     advance,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         bubble_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    logic [NUM_MEM_PORTS-1:0] port_ok;
    logic [NUM_MEM_PORTS-1:0] done_q;
    logic [NUM_MEM_PORTS-1:0] done_d;
    logic [NUM_STAGES-1:0]    valid_q;
    logic [NUM_STAGES-1:0]    valid_d;
    logic                     flush_pending_q;
    logic                     flush_pending_d;
    logic                     eff_flush;
    shift_mode_e              mode;

    // A port is satisfied if idle, answering now, or answered earlier in
    // this stall; a response on an idle port never latches done.
    for (genvar p = 0; p < NUM_MEM_PORTS; p++) begin : g_port
        assign port_ok[p] = !mem_req[p] | mem_resp[p] | done_q[p];
        assign done_d[p]  = advance ? 1'b0 : (done_q[p] | (mem_req[p] & mem_resp[p]));
    end

    assign advance         = rst_n & (&port_ok);
    assign eff_flush       = flush | flush_pending_q;
    assign flush_pending_d = advance ? 1'b0 : eff_flush;

    always_comb begin
        mode = SHIFT_HOLD;
        if (advance) begin
            if (eff_flush) begin
                mode = SHIFT_FLUSH;
            end else if (hazard) begin
                mode = SHIFT_HAZARD;
            end else begin
                mode = SHIFT_NORMAL;
            end
        end
    end

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        logic prev_valid;

        if (i == 0) begin : g_head
            assign prev_valid = fetch_valid;
        end else begin : g_body
            assign prev_valid = valid_q[i-1];
        end

        always_comb begin
            stage_load[i] = 1'b0;
            valid_d[i]    = valid_q[i];
            case (mode)
                SHIFT_NORMAL: begin
                    stage_load[i] = 1'b1;
                    valid_d[i]    = prev_valid;
                end
                SHIFT_FLUSH: begin
                    stage_load[i] = 1'b1;
                    valid_d[i]    = (i < FLUSH_DEPTH) ? 1'b0 : prev_valid;
                end
                SHIFT_HAZARD: begin
                    // Stages up to the hazard freeze; the one behind them takes a bubble.
                    if (i > HAZ_STAGE) begin
                        stage_load[i] = 1'b1;
                        valid_d[i]    = (i == HAZ_STAGE + 1) ? 1'b0 : prev_valid;
                    end
                end
                default: begin
                    stage_load[i] = 1'b0;
                    valid_d[i]    = valid_q[i];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q         <= '0;
            done_q          <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            valid_q         <= valid_d;
            done_q          <= done_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    assign stage_valid = valid_q;

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!advance),
        .count (stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mode == SHIFT_HAZARD),
        .count (bubble_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mode == SHIFT_FLUSH),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a default build driven cycle by cycle
// and a CNT_W=4 build for counter saturation and mid-stall reset.
module tb_pipeline_ctrl;
    import rv32i_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n       = 1'b0;
    logic [1:0]  mem_req     = 2'b00;
    logic [1:0]  mem_resp    = 2'b00;
    logic        fetch_valid = 1'b0;
    logic        hazard      = 1'b0;
    logic        flush       = 1'b0;
    logic [4:0]  stage_load;
    logic [4:0]  stage_valid;
    logic        advance;
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;

    pipeline_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_resp    (mem_resp),
        .fetch_valid (fetch_valid),
        .hazard      (hazard),
        .flush       (flush),
        .stage_load  (stage_load),
        .stage_valid (stage_valid),
        .advance     (advance),
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt),
        .flush_cnt   (flush_cnt)
    );

    logic        rst2_n   = 1'b0;
    logic [1:0]  mem_req2 = 2'b00;
    logic [1:0]  mem_resp2 = 2'b00;
    logic        fv2      = 1'b0;
    logic        hz2      = 1'b0;
    logic        fl2      = 1'b0;
    logic [4:0]  load2;
    logic [4:0]  valid2;
    logic        adv2;
    logic [3:0]  stall2;
    logic [3:0]  bubble2;
    logic [3:0]  flushc2;

    pipeline_ctrl #(.CNT_W(4)) dut_sat (
        .clk         (clk),
        .rst_n       (rst2_n),
        .mem_req     (mem_req2),
        .mem_resp    (mem_resp2),
        .fetch_valid (fv2),
        .hazard      (hz2),
        .flush       (fl2),
        .stage_load  (load2),
        .stage_valid (valid2),
        .advance     (adv2),
        .stall_cnt   (stall2),
        .bubble_cnt  (bubble2),
        .flush_cnt   (flushc2)
    );

    typedef struct {
        logic [4:0]  load;
        logic [4:0]  valid;
        logic [31:0] s;
        logic [31:0] b;
        logic [31:0] f;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One controller cycle: drive inputs just after the edge and, if an
    // advance is expected, queue the outcome the monitor should observe.
    task automatic cyc(input logic [1:0] req, input logic [1:0] resp, input logic fv,
                       input logic hz, input logic fl, input logic adv,
                       input logic [4:0] ld, input logic [4:0] vl,
                       input int s, input int b, input int f);
        exp_t e;
        @(posedge clk);
        #2;
        mem_req     = req;
        mem_resp    = resp;
        fetch_valid = fv;
        hazard      = hz;
        flush       = fl;
        rst_n       = 1'b1;
        if (adv) begin
            e.load  = ld;
            e.valid = vl;
            e.s     = s;
            e.b     = b;
            e.f     = f;
            q.push_back(e);
        end
    endtask

    // Monitor: every advance of the main DUT is matched against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (advance) begin
                if (q.size() == 0) begin
                    chk("unexpected_advance", 32'(advance), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("stage_load", 32'(stage_load), 32'(e.load));
                    @(posedge clk);
                    #1;
                    chk("stage_valid", 32'(stage_valid), 32'(e.valid));
                    chk("stall_cnt", stall_cnt, e.s);
                    chk("bubble_cnt", bubble_cnt, e.b);
                    chk("flush_cnt", flush_cnt, e.f);
                end
            end else if (rst_n) begin
                chk("stall_load_zero", 32'(stage_load), 32'd0);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #3;
        chk("rst_valid", 32'(stage_valid), 32'd0);
        chk("rst_load", 32'(stage_load), 32'd0);
        chk("rst_advance", 32'(advance), 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_bubble", bubble_cnt, 32'd0);
        chk("rst_flush", flush_cnt, 32'd0);

        // imem answers first, dmem three cycles later
        cyc(2'b11, 2'b01, 1, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
        cyc(2'b11, 2'b00, 1, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
        cyc(2'b11, 2'b00, 1, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
        cyc(2'b11, 2'b10, 1, 0, 0, 1, 5'b11111, 5'b00001, 3, 0, 0);
        // fill the pipe
        cyc(2'b00, 2'b00, 1, 0, 0, 1, 5'b11111, 5'b00011, 3, 0, 0);
        cyc(2'b00, 2'b00, 1, 0, 0, 1, 5'b11111, 5'b00111, 3, 0, 0);
        cyc(2'b00, 2'b00, 1, 0, 0, 1, 5'b11111, 5'b01111, 3, 0, 0);
        cyc(2'b00, 2'b00, 1, 0, 0, 1, 5'b11111, 5'b11111, 3, 0, 0);
        // load-use hazard, then a plain shift
        cyc(2'b00, 2'b00, 1, 1, 0, 1, 5'b11100, 5'b11011, 3, 1, 0);
        cyc(2'b00, 2'b00, 0, 0, 0, 1, 5'b11111, 5'b10110, 3, 1, 0);
        // flush during stall is remembered until the advance
        cyc(2'b01, 2'b00, 1, 0, 1, 0, 5'b00000, 5'b00000, 0, 0, 0);
        cyc(2'b01, 2'b00, 1, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
        cyc(2'b01, 2'b01, 1, 0, 0, 1, 5'b11111, 5'b01100, 5, 1, 1);
        cyc(2'b00, 2'b00, 1, 0, 0, 1, 5'b11111, 5'b11001, 5, 1, 1);
        // flush beats hazard
        cyc(2'b00, 2'b00, 1, 1, 1, 1, 5'b11111, 5'b10000, 5, 1, 2);
        // response on an unrequested port must not latch done
        cyc(2'b10, 2'b01, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
        cyc(2'b11, 2'b10, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
        cyc(2'b11, 2'b01, 1, 0, 0, 1, 5'b11111, 5'b00001, 7, 1, 2);
        // hazard on advance vs hazard during stall
        cyc(2'b00, 2'b00, 1, 1, 0, 1, 5'b11100, 5'b00001, 7, 2, 2);
        cyc(2'b01, 2'b00, 0, 1, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
        cyc(2'b01, 2'b01, 0, 0, 0, 1, 5'b11111, 5'b00010, 8, 2, 2);
        cyc(2'b01, 2'b00, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
        repeat (4) @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'd0);

        // CNT_W=4 build: fill three stages, then stall long enough to saturate
        @(posedge clk);
        #2;
        mem_req2  = 2'b00;
        fv2       = 1'b1;
        rst2_n    = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        mem_req2[IMEM_PORT] = 1'b1;
        fl2 = 1'b1;
        @(posedge clk);
        #2;
        fl2 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("sat_stall_15", 32'(stall2), 32'd15);
        chk("sat_valid_held", 32'(valid2), 32'b00111);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_stall_hold", 32'(stall2), 32'd15);
        #1;
        rst2_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid2), 32'd0);
        chk("arst_stall", 32'(stall2), 32'd0);
        chk("arst_flush", 32'(flushc2), 32'd0);
        chk("arst_advance", 32'(adv2), 32'd0);
        chk("arst_load", 32'(load2), 32'd0);
        @(posedge clk);
        #2;
        mem_req2  = 2'b00;
        fv2       = 1'b0;
        rst2_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("fresh_valid", 32'(valid2), 32'd0);
        chk("fresh_flush_cnt", 32'(flushc2), 32'd0);
        chk("fresh_stall_cnt", 32'(stall2), 32'd0);
        mem_req2[DMEM_PORT] = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, 5, number of tracked pipeline stages, minimum 3.
REQ-002 SHALL have parameter NUM_MEM_PORTS, 2, number of memory ports gating advance (0 = imem, 1 = dmem).
REQ-003 SHALL have parameter HAZ_STAGE, 1, index of the stage held on a load-use hazard; HAZ_STAGE < NUM_STAGES-1.
REQ-004 SHALL have parameter FLUSH_DEPTH, 2, number of youngest stages (0..FLUSH_DEPTH-1) killed on flush.
REQ-005 SHALL have parameter CNT_W, 32, performance counter width.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 Port: clk  input  1  rising-edge clock.
REQ-008 Port: rst_n  input  1  asynchronous active-low reset.
REQ-009 Port: mem_req  input  NUM_MEM_PORTS  port p has an outstanding request this cycle.
REQ-010 Port: mem_resp  input  NUM_MEM_PORTS  port p response, 1-cycle pulse.
REQ-011 Port: fetch_valid  input  1  stage 0 receives a real instruction on advance.
REQ-012 Port: hazard  input  1  load-use hazard detected at HAZ_STAGE.
REQ-013 Port: flush  input  1  branch misprediction resolved; kill younger stages.
REQ-014 Port: stage_load  output  NUM_STAGES  load enable for the register of stage i.
REQ-015 Port: stage_valid  output  NUM_STAGES  stage i holds a real instruction.
REQ-016 Port: advance  output  1  pipeline moves this cycle.
REQ-017 Port: stall_cnt, bubble_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-018 SHALL keep a per-port done flag: set when mem_resp[p]=1 and advance=0; cleared when advance=1; held otherwise.
REQ-019 advance SHALL be combinational: AND over p of (!mem_req[p] | mem_resp[p] | done[p]).
REQ-020 If advance=0, stage_load SHALL be all 0 and stage_valid SHALL hold.
REQ-021 On advance with no flush and no hazard: stage_load all 1; valid[0] <= fetch_valid; valid[i] <= valid[i-1] for i ≥ 1.
REQ-022 On advance with hazard and no flush: stage_load[0..HAZ_STAGE] = 0 and those stages hold; valid[HAZ_STAGE+1] <= 0 (bubble); stages above HAZ_STAGE+1 shift normally.
REQ-023 On advance with effective flush: stage_load all 1; valid[0..FLUSH_DEPTH-1] <= 0; older stages shift normally; hazard is ignored.
REQ-024 Effective flush = flush | flush_pending. flush_pending SHALL be set by flush while advance=0 and cleared on advance.
REQ-025 stall_cnt SHALL increment each cycle advance=0.
REQ-026 bubble_cnt SHALL increment on each cycle covered by REQ-022.
REQ-027 flush_cnt SHALL increment on each advance covered by REQ-023.
REQ-028 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 A response on a port with mem_req=0 SHALL be ignored and SHALL NOT set done.
REQ-030 Latency SHALL be zero cycles from the last outstanding response to advance=1.

Reset
REQ-031 On rst_n=0, asynchronously: stage_valid=0, done=0, flush_pending=0, all counters=0.
REQ-032 During reset, stage_load SHALL be 0 and advance SHALL be 0.
REQ-033 Reset asserted mid-stall SHALL discard pending done and flush state; the first cycle after release SHALL behave as a fresh start.

Structure
REQ-034 Parameter defaults and the port-index constants (IMEM_PORT=0, DMEM_PORT=1) SHALL live in the shared rv32i_types package.
REQ-035 A saturating counter sub-module perf_counter (CNT_W, inc, count) SHALL be instantiated three times.
REQ-036 The advance logic and the stage_load/valid shift logic SHALL be generate loops over NUM_MEM_PORTS and NUM_STAGES.

Verification (defaults)
REQ-037 Imem and dmem both requested; imem resp at cycle 2, dmem resp at cycle 5 -> advance=1 only at cycle 5; stall_cnt=3.
REQ-038 fetch_valid=1 for 5 consecutive advances from reset -> stage_valid=5'b11111.
REQ-039 hazard=1 for one advance with stage_valid=11111 -> stage_load=11100; stage_valid=11011; bubble_cnt=1.
REQ-040 flush pulse while advance=0, responses arrive 2 cycles later -> on that advance valid[1:0]=00; flush_cnt=1; flush_pending=0.
REQ-041 flush and hazard together on advance -> flush wins: stage_load=11111, valid[1:0]=00, bubble_cnt unchanged.
REQ-042 Force stall_cnt to 2^CNT_W-1 (CNT_W=4 build) with continued stall -> stall_cnt holds at 15; then assert rst_n=0 mid-stall -> all outputs 0 asynchronously.
